// File: rtl/move_resolver.sv
// Resolves one selected move: rolls an 8-bit LFSR against accuracy, then drains defender HP one point
// every DRAIN_DIV cycles. Optional build macro CRIT_HIT_EN enables critical hits (double damage).
module move_resolver #(
  parameter int         HP_W      = 8,
  parameter int         HP_INIT   = 100,
  parameter int         DRAIN_DIV = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      dmg,
  input  logic [3:0]      accu,
  input  logic            new_battle,
  output logic            busy,
  output logic            done,
  output logic            hit,
  output logic            crit,
  output logic [HP_W-1:0] hp,
  output logic            fainted
);

  localparam int TW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROLL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      lfsr;
  logic [3:0]      dmg_q, accu_q;
  logic [4:0]      drain_cnt;
  logic [TW-1:0]   tick;
  logic            roll_hit;
  logic            tick_term;
  logic            hp_last;
  logic            accept;
  logic [4:0]      eff_dmg;

  // Handshake: start is a request that is accepted only when the FSM sits in IDLE with a living
  // defender and no new_battle in the same cycle; anything arriving while busy is dropped.
  assign accept    = (state == IDLE) && start && !new_battle && !fainted;
  assign roll_hit  = (accu_q == 4'hF) || (lfsr[3:0] < accu_q);
  assign tick_term = (tick == TW'(DRAIN_DIV - 1));
  assign hp_last   = (hp == HP_W'(1));

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign fainted = (hp == '0);

`ifdef CRIT_HIT_EN
  logic roll_crit;
  logic crit_q;
  assign roll_crit = roll_hit && (lfsr[7:4] == 4'h0);
  assign eff_dmg   = roll_crit ? {dmg_q, 1'b0} : {1'b0, dmg_q};
  assign crit      = crit_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      crit_q <= 1'b0;
    end else if (accept) begin
      crit_q <= 1'b0;
    end else if (state == ROLL) begin
      crit_q <= roll_crit;
    end
  end
`else
  assign eff_dmg = {1'b0, dmg_q};
  assign crit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ROLL;
      ROLL:  if (!roll_hit || (eff_dmg == 5'd0)) state_nxt = DONE;
             else state_nxt = DRAIN;
      DRAIN: if (tick_term && ((drain_cnt == 5'd1) || hp_last)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // LFSR free-runs every cycle, so the roll depends on how long the FSM idled.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= LFSR_SEED;
      hp        <= HP_W'(HP_INIT);
      hit       <= 1'b0;
      dmg_q     <= 4'd0;
      accu_q    <= 4'd0;
      drain_cnt <= 5'd0;
      tick      <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      case (state)
        IDLE: begin
          if (new_battle) begin
            hp <= HP_W'(HP_INIT);
          end else if (accept) begin
            dmg_q  <= dmg;
            accu_q <= accu;
            hit    <= 1'b0;
          end
        end
        ROLL: begin
          hit       <= roll_hit;
          drain_cnt <= eff_dmg;
          tick      <= '0;
        end
        DRAIN: begin
          if (tick_term) begin
            tick      <= '0;
            drain_cnt <= drain_cnt - 5'd1;
            if (hp != '0) hp <= hp - HP_W'(1);
          end else begin
            tick <= tick + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
